id_ex_decode: RTL and testbench
===============================

# id_ex_decode

Decode stage and ID/EX pipeline register that drives the execute-stage ALU. It converts a 32-bit instruction into the ALU control word (`ALUControlE`, `ALUSrcE`, `SignImmE`) and the forwarding selects (`sel_1`, `sel_2`). It tracks the EX and MEM stages to detect load-use hazards, which it resolves by stalling fetch and inserting bubbles. It sits between the IF/ID register and the ALU.

## Interface
Parameters:
- `REG_AW`, 4: register address width (16 registers, r0 hardwired zero).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_d` in 32: instruction in decode.
- `valid_d` in 1: `instr_d` is valid.
- `flush` in 1: kill the decode-stage instruction (branch redirect).
- `stall_d` out 1: combinational; hold IF/ID this cycle.
- `rs1_d`, `rs2_d` out `REG_AW`: combinational register-file read addresses.
- `ALUControlE` out 3: 000 add, 111 and, 110 or.
- `ALUSrcE` out 1: 1 selects immediate as operand B.
- `SignImmE` out 12: raw immediate `instr[11:0]`.
- `sel_1`, `sel_2` out 1: forward `alu_MEM` into operand A / operand B.
- `valid_e`, `reg_write_e`, `mem_read_e`, `mem_write_e` out 1: EX-stage qualifiers.
- `rd_e` out `REG_AW`: EX-stage destination register.
- `illegal_e` out 1: EX instruction had an undefined opcode.

## Operation
- Fields: opcode `[31:28]`, rd `[27:24]`, rs1 `[23:20]`, rs2 `[19:16]`, imm `[11:0]`.
- Opcodes and decoded effect:
  - 0000 ADD, 0001 AND, 0010 OR: `ALUSrcE`=0, `reg_write`=1.
  - 0100 ADDI, 0101 ANDI, 0110 ORI: `ALUSrcE`=1, `reg_write`=1.
  - 1000 LW: add, `ALUSrcE`=1, `reg_write`=1, `mem_read`=1.
  - 1001 SW: add, `ALUSrcE`=1, `mem_write`=1. Reads rs2 as store data.
  - 1111 NOP: bubble.
  - Any other opcode: bubble fields with `illegal`=1 (`valid_e`=1).
- Register-use rules:
  - `reg_write` forced 0 when rd=0.
  - rs2 is "used" only for R-type and SW.
  - rs1 is used by all opcodes except NOP and illegal.
- MEM-stage shadow registers (internal): `rd_m`, `reg_write_m`, `mem_read_m`, `valid_m`. These load from the EX outputs every cycle.
- Forwarding:
  - `sel_1` is registered as 1 when all hold: rs1 is used, rs1==`rd_e`, `valid_e`, `reg_write_e`, !`mem_read_e`. The next EX instruction then sees that producer in MEM.
  - `sel_2` uses the same rule with rs2.
  - Loads never forward. Their data arrives via register-file write-before-read in WB.
- Load-use detection:
  - `stall_d` = `valid_d` & !`flush` & (a used source matches the rd of a valid `mem_read` in EX, or of one in MEM, with rd≠0).
  - An immediately dependent instruction therefore stalls 2 cycles; one with a single intervening instruction stalls 1 cycle.
- Update rules:
  - Stall cycle: ID/EX loads a bubble; `instr_d` is held upstream.
  - `flush`: ID/EX loads a bubble, `stall_d`=0. `flush` overrides stall.
  - `valid_d`=0: ID/EX loads a bubble.
- Bubble contents: all EX outputs 0 (`ALUControlE`=000, `SignImmE`=0, `sel_*`=0, `valid_e`=0).

## Timing
- Decode-to-EX latency: 1 cycle. All E outputs change only on the rising edge or on reset.
- `stall_d`, `rs1_d` and `rs2_d` are combinational from `instr_d`/`valid_d` and the registered state. There are no paths from E outputs back into themselves within a cycle.
- Reset: all registered outputs and MEM shadows clear to 0 immediately, with no clock required.
  - `stall_d` follows from the cleared state (0 unless the IF/ID entry depends on nothing, which gives 0).
  - Reset asserted mid-stall discards the stalled context.
- Simultaneous `flush` and hazard: bubble, no stall.
- Both operands matching the same MEM producer: `sel_1`=`sel_2`=1.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants.
  - ALU control codes `ALU_ADD`=000, `ALU_AND`=111, `ALU_OR`=110.
  - Field bit positions.
  - Bubble control word constant.
- Sub-module `instr_decoder`: purely combinational. Takes the opcode and outputs the control word, reg_write/mem flags, rs-used bits and illegal.
- Top-level logic: hazard/forward comparators, ID/EX register, MEM shadow register.

## Test plan
- ADD r1,r2,r3 then AND r4,r1,r5 → second instruction in EX has `ALUControlE`=111, `sel_1`=1, `sel_2`=0, `stall_d` never high.
- LW r6,0(r2) then ADD r7,r6,r6 → `stall_d` high 2 cycles, 2 bubbles, ADD reaches EX with `sel_1`=`sel_2`=0.
- LW r6, ORI r8,r9,0x0F0, ADD r7,r6,r1 → one stall cycle. ORI in EX shows `ALUSrcE`=1, `SignImmE`=0x0F0, `ALUControlE`=110.
- ADDI r0,r1,5 then ADD r2,r0,r0 → `reg_write_e`=0 for ADDI, `sel_1`=`sel_2`=0.
- Hazard condition with `flush`=1 in the same cycle → `stall_d`=0, next `valid_e`=0. Opcode 0xA → `illegal_e`=1, `reg_write_e`=0.
- Assert `rst` mid-stall → all E outputs 0 without a clock edge. After release, `valid_e` stays 0 until a valid instruction is decoded.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU control codes,
// instruction field positions and the decoded control word layout.
package cpu_pkg;

  // Opcodes (instr[31:28])
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_ANDI = 4'b0101;
  localparam logic [3:0] OP_ORI  = 4'b0110;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_OR  = 3'b110;

  // Instruction field positions (LSB of each field)
  localparam int OPC_LSB = 28;
  localparam int OPC_W   = 4;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 12;

  // Decoded control word produced by instr_decoder.
  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       rs1_used;
    logic       rs2_used;
    logic       illegal;
    logic       bubble;    // opcode is an explicit NOP
  } ctrl_t;

  // Everything off: what a bubble looks like before any opcode is applied.
  localparam ctrl_t CTRL_BUBBLE = '{
    alu_ctrl:  ALU_ADD,
    alu_src:   1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    rs1_used:  1'b0,
    rs2_used:  1'b0,
    illegal:   1'b0,
    bubble:    1'b0
  };

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode decoder: opcode -> control word.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o
);

  // Opcode lookup; unknown opcodes decode as a bubble flagged illegal.
  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    case (opcode_i)
      OP_ADD, OP_AND, OP_OR: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.rs1_used  = 1'b1;
        ctrl_o.rs2_used  = 1'b1;
        ctrl_o.alu_ctrl  = (opcode_i == OP_AND) ? ALU_AND :
                           (opcode_i == OP_OR)  ? ALU_OR  : ALU_ADD;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.rs1_used  = 1'b1;
        ctrl_o.alu_ctrl  = (opcode_i == OP_ANDI) ? ALU_AND :
                           (opcode_i == OP_ORI)  ? ALU_OR  : ALU_ADD;
      end
      OP_LW: begin
        ctrl_o.alu_ctrl  = ALU_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.rs1_used  = 1'b1;
      end
      OP_SW: begin
        // rs2 carries the store data, so it counts as a source.
        ctrl_o.alu_ctrl  = ALU_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.rs1_used  = 1'b1;
        ctrl_o.rs2_used  = 1'b1;
      end
      OP_NOP: begin
        ctrl_o.bubble = 1'b1;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_decode.sv
// Decode stage plus ID/EX pipeline register. Detects load-use hazards
// against EX and MEM, stalls fetch, inserts bubbles and computes the
// registered forwarding selects for the EX operands.
//
// Handshake: the upstream IF/ID entry (instr_d, valid_d) is consumed on a
// rising edge when valid_d=1, flush=0 and stall_d=0; while stall_d=1 the
// upstream must hold instr_d/valid_d unchanged and a bubble enters EX.
module id_ex_decode
  import cpu_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic              valid_d,
  input  logic              flush,
  output logic              stall_d,
  output logic [REG_AW-1:0] rs1_d,
  output logic [REG_AW-1:0] rs2_d,
  output logic [2:0]        ALUControlE,
  output logic              ALUSrcE,
  output logic [IMM_W-1:0]  SignImmE,
  output logic              sel_1,
  output logic              sel_2,
  output logic              valid_e,
  output logic              reg_write_e,
  output logic              mem_read_e,
  output logic              mem_write_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              illegal_e
);

  ctrl_t             dec;
  logic [REG_AW-1:0] rd_f;
  logic [IMM_W-1:0]  imm_f;
  logic              unused_bits;

  // ID/EX register
  logic [2:0]        alu_q,  alu_d;
  logic              src_q,  src_d;
  logic [IMM_W-1:0]  imm_q,  imm_d;
  logic              sel1_q, sel1_d;
  logic              sel2_q, sel2_d;
  logic              vld_q,  vld_d;
  logic              rw_q,   rw_d;
  logic              mr_q,   mr_d;
  logic              mw_q,   mw_d;
  logic [REG_AW-1:0] rd_q,   rd_d;
  logic              ill_q,  ill_d;

  // MEM-stage shadow of the producer that just left EX
  logic [REG_AW-1:0] rd_m_q;
  logic              reg_write_m_q;
  logic              mem_read_m_q;
  logic              valid_m_q;

  logic load_ex, load_mem, fwd_ok, hazard, issue;

  assign rs1_d       = instr_d[RS1_LSB +: REG_AW];
  assign rs2_d       = instr_d[RS2_LSB +: REG_AW];
  assign rd_f        = instr_d[RD_LSB  +: REG_AW];
  assign imm_f       = instr_d[IMM_LSB +: IMM_W];
  assign unused_bits = ^{instr_d[15:12], reg_write_m_q};

  instr_decoder u_dec (
    .opcode_i (instr_d[OPC_LSB +: OPC_W]),
    .ctrl_o   (dec)
  );

  // Hazard/forward comparators and next-state of the ID/EX register.
  always_comb begin
    load_ex  = vld_q & mr_q & (rd_q != '0);
    load_mem = valid_m_q & mem_read_m_q & (rd_m_q != '0);
    fwd_ok   = vld_q & rw_q & ~mr_q;

    hazard = (dec.rs1_used & ((load_ex  & (rs1_d == rd_q)) |
                              (load_mem & (rs1_d == rd_m_q)))) |
             (dec.rs2_used & ((load_ex  & (rs2_d == rd_q)) |
                              (load_mem & (rs2_d == rd_m_q))));

    stall_d = valid_d & ~flush & hazard;
    issue   = valid_d & ~flush & ~hazard & ~dec.bubble;

    alu_d  = ALU_ADD;
    src_d  = 1'b0;
    imm_d  = '0;
    sel1_d = 1'b0;
    sel2_d = 1'b0;
    vld_d  = 1'b0;
    rw_d   = 1'b0;
    mr_d   = 1'b0;
    mw_d   = 1'b0;
    rd_d   = '0;
    ill_d  = 1'b0;

    if (issue) begin
      vld_d = 1'b1;
      ill_d = dec.illegal;
      if (!dec.illegal) begin
        alu_d  = dec.alu_ctrl;
        src_d  = dec.alu_src;
        imm_d  = imm_f;
        rd_d   = rd_f;
        rw_d   = dec.reg_write & (rd_f != '0);
        mr_d   = dec.mem_read;
        mw_d   = dec.mem_write;
        sel1_d = dec.rs1_used & fwd_ok & (rs1_d == rd_q);
        sel2_d = dec.rs2_used & fwd_ok & (rs2_d == rd_q);
      end
    end
  end

  // ID/EX register and MEM shadows; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q         <= ALU_ADD;
      src_q         <= 1'b0;
      imm_q         <= '0;
      sel1_q        <= 1'b0;
      sel2_q        <= 1'b0;
      vld_q         <= 1'b0;
      rw_q          <= 1'b0;
      mr_q          <= 1'b0;
      mw_q          <= 1'b0;
      rd_q          <= '0;
      ill_q         <= 1'b0;
      rd_m_q        <= '0;
      reg_write_m_q <= 1'b0;
      mem_read_m_q  <= 1'b0;
      valid_m_q     <= 1'b0;
    end else begin
      alu_q         <= alu_d;
      src_q         <= src_d;
      imm_q         <= imm_d;
      sel1_q        <= sel1_d;
      sel2_q        <= sel2_d;
      vld_q         <= vld_d;
      rw_q          <= rw_d;
      mr_q          <= mr_d;
      mw_q          <= mw_d;
      rd_q          <= rd_d;
      ill_q         <= ill_d;
      rd_m_q        <= rd_q;
      reg_write_m_q <= rw_q;
      mem_read_m_q  <= mr_q;
      valid_m_q     <= vld_q;
    end
  end

  assign ALUControlE = alu_q;
  assign ALUSrcE     = src_q;
  assign SignImmE    = imm_q;
  assign sel_1       = sel1_q;
  assign sel_2       = sel2_q;
  assign valid_e     = vld_q;
  assign reg_write_e = rw_q;
  assign mem_read_e  = mr_q;
  assign mem_write_e = mw_q;
  assign rd_e        = rd_q;
  assign illegal_e   = ill_q;

endmodule

// File: tb/tb_id_ex_decode.sv
// Bench for id_ex_decode: reference model feeds an expected-EX queue,
// plus directed checks of the documented scenarios.
module tb_id_ex_decode;

  localparam int W = 27;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        flush;
  logic        stall_d;
  logic [3:0]  rs1_d, rs2_d;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic [11:0] SignImmE;
  logic        sel_1, sel_2;
  logic        valid_e, reg_write_e, mem_read_e, mem_write_e;
  logic [3:0]  rd_e;
  logic        illegal_e;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];

  // reference model state: EX and MEM
  logic       m_valid, m_rw, m_mr;
  logic [3:0] m_rd;
  logic       mm_valid, mm_mr;
  logic [3:0] mm_rd;

  id_ex_decode #(.REG_AW(4)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .flush(flush),
    .stall_d(stall_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .SignImmE(SignImmE),
    .sel_1(sel_1), .sel_2(sel_2), .valid_e(valid_e), .reg_write_e(reg_write_e),
    .mem_read_e(mem_read_e), .mem_write_e(mem_write_e), .rd_e(rd_e),
    .illegal_e(illegal_e)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_word();
    return {valid_e, illegal_e, reg_write_e, mem_read_e, mem_write_e, rd_e,
            ALUControlE, ALUSrcE, SignImmE, sel_1, sel_2};
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] r1, input logic [3:0] r2,
                                     input logic [11:0] imm);
    return {op, rd, r1, r2, 4'h0, imm};
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_rd = 0;
    mm_valid = 0; mm_mr = 0; mm_rd = 0;
  endtask

  // One clock: drive, check combinational outputs, predict and check EX.
  task automatic step(input logic [31:0] ins, input logic v, input logic fl,
                      output logic stalled);
    logic [3:0] op, rd, r1, r2;
    logic [11:0] imm;
    logic u1, u2, rw, mr, mw, src, ill, nop, ldex, ldmm, fwd, s1, s2, h, es, iss;
    logic [2:0] alu;
    logic [W-1:0] nw, got, exp;
    instr_d = ins; valid_d = v; flush = fl;
    op = ins[31:28]; rd = ins[27:24]; r1 = ins[23:20]; r2 = ins[19:16];
    imm = ins[11:0];
    u1 = 0; u2 = 0; rw = 0; mr = 0; mw = 0; src = 0; ill = 0; nop = 0; alu = 3'b000;
    case (op)
      4'h0: begin u1 = 1; u2 = 1; rw = 1; end
      4'h1: begin u1 = 1; u2 = 1; rw = 1; alu = 3'b111; end
      4'h2: begin u1 = 1; u2 = 1; rw = 1; alu = 3'b110; end
      4'h4: begin u1 = 1; src = 1; rw = 1; end
      4'h5: begin u1 = 1; src = 1; rw = 1; alu = 3'b111; end
      4'h6: begin u1 = 1; src = 1; rw = 1; alu = 3'b110; end
      4'h8: begin u1 = 1; src = 1; rw = 1; mr = 1; end
      4'h9: begin u1 = 1; u2 = 1; src = 1; mw = 1; end
      4'hF: nop = 1;
      default: ill = 1;
    endcase
    if (rd == 4'd0) rw = 0;
    ldex = m_valid & m_mr & (m_rd != 0);
    ldmm = mm_valid & mm_mr & (mm_rd != 0);
    h = (u1 & ((ldex & (r1 == m_rd)) | (ldmm & (r1 == mm_rd)))) |
        (u2 & ((ldex & (r2 == m_rd)) | (ldmm & (r2 == mm_rd))));
    es = v & ~fl & h;
    fwd = m_valid & m_rw & ~m_mr;
    s1 = u1 & fwd & (r1 == m_rd);
    s2 = u2 & fwd & (r2 == m_rd);
    iss = v & ~fl & ~es & ~nop;
    #1;
    vectors++;
    if (stall_d !== es) begin
      miscompares++;
      $display("FAIL stall_d ins=%h: got %b want %b", ins, stall_d, es);
    end
    vectors++;
    if ({rs1_d, rs2_d} !== {r1, r2}) begin
      miscompares++;
      $display("FAIL rs_d ins=%h: got %h want %h", ins, {rs1_d, rs2_d}, {r1, r2});
    end
    if (!iss) nw = '0;
    else if (ill) nw = {1'b1, 1'b1, 25'd0};
    else nw = {1'b1, 1'b0, rw, mr, mw, rd, alu, src, imm, s1, s2};
    exp_q.push_back(nw);
    mm_valid = m_valid; mm_mr = m_mr; mm_rd = m_rd;
    m_valid = iss; m_rw = iss & ~ill & rw; m_mr = iss & ~ill & mr;
    m_rd = (iss & ~ill) ? rd : 4'd0;
    @(posedge clk); #1;
    got = dut_word();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL ex_word ins=%h: got %h want %h", ins, got, exp);
    end
    stalled = es;
  endtask

  // Present an instruction until it is accepted; return stall cycles.
  task automatic issue(input logic [31:0] ins, output int stalls);
    logic s;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step(ins, 1'b1, 1'b0, s);
      if (!s) return;
      stalls++;
    end
    vectors++;
    miscompares++;
    $display("FAIL issue_timeout ins=%h: stalled %0d cycles, want < 8", ins, stalls);
  endtask

  task automatic test_reset();
    rst = 1; instr_d = 0; valid_d = 0; flush = 0;
    model_clear();
    #3;
    vectors++;
    if ({dut_word(), stall_d} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", {dut_word(), stall_d});
    end
    #4 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_forward_alu();
    int st0, st1;
    issue(mk(4'h0, 4'd1, 4'd2, 4'd3, 12'h0), st0);
    issue(mk(4'h1, 4'd4, 4'd1, 4'd5, 12'h0), st1);
    vectors++;
    if ({ALUControlE, sel_1, sel_2, st0[3:0], st1[3:0]} !== {3'b111, 1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL fwd_alu: got alu=%b s1=%b s2=%b stalls=%0d/%0d want 111 1 0 0/0",
               ALUControlE, sel_1, sel_2, st0, st1);
    end
  endtask

  task automatic test_load_use_2();
    int st;
    issue(mk(4'h8, 4'd6, 4'd2, 4'd0, 12'h0), st);
    issue(mk(4'h0, 4'd7, 4'd6, 4'd6, 12'h0), st);
    vectors++;
    if (st !== 2 || {valid_e, sel_1, sel_2} !== 3'b100) begin
      miscompares++;
      $display("FAIL load_use_2: got stalls=%0d v/s1/s2=%b want 2 100", st,
               {valid_e, sel_1, sel_2});
    end
  endtask

  task automatic test_load_use_1();
    int st;
    issue(mk(4'h8, 4'd6, 4'd2, 4'd0, 12'h0), st);
    issue(mk(4'h6, 4'd8, 4'd9, 4'd0, 12'h0F0), st);
    vectors++;
    if ({ALUSrcE, SignImmE, ALUControlE} !== {1'b1, 12'h0F0, 3'b110} || st !== 0) begin
      miscompares++;
      $display("FAIL ori_ex: got src=%b imm=%h alu=%b stalls=%0d want 1 0f0 110 0",
               ALUSrcE, SignImmE, ALUControlE, st);
    end
    issue(mk(4'h0, 4'd7, 4'd6, 4'd1, 12'h0), st);
    vectors++;
    if (st !== 1) begin
      miscompares++;
      $display("FAIL load_use_1: got stalls=%0d want 1", st);
    end
  endtask

  task automatic test_r0();
    int st;
    issue(mk(4'h4, 4'd0, 4'd1, 4'd0, 12'd5), st);
    vectors++;
    if ({valid_e, reg_write_e} !== 2'b10) begin
      miscompares++;
      $display("FAIL r0_write: got v/rw=%b want 10", {valid_e, reg_write_e});
    end
    issue(mk(4'h0, 4'd2, 4'd0, 4'd0, 12'h0), st);
    vectors++;
    if ({sel_1, sel_2} !== 2'b00) begin
      miscompares++;
      $display("FAIL r0_fwd: got %b want 00", {sel_1, sel_2});
    end
  endtask

  task automatic test_back_to_back();
    int st;
    issue(mk(4'h2, 4'd3, 4'd4, 4'd5, 12'h0), st);
    issue(mk(4'h0, 4'd9, 4'd3, 4'd3, 12'h0), st);
    vectors++;
    if ({sel_1, sel_2} !== 2'b11) begin
      miscompares++;
      $display("FAIL both_fwd: got %b want 11", {sel_1, sel_2});
    end
    issue(mk(4'h9, 4'd0, 4'd1, 4'd9, 12'h004), st);
    vectors++;
    if ({mem_write_e, sel_1, sel_2, reg_write_e} !== 4'b1010) begin
      miscompares++;
      $display("FAIL sw_fwd: got mw/s1/s2/rw=%b want 1010",
               {mem_write_e, sel_1, sel_2, reg_write_e});
    end
  endtask

  task automatic test_flush_illegal();
    int st;
    logic s;
    issue(mk(4'h8, 4'd6, 4'd2, 4'd0, 12'h0), st);
    step(mk(4'h0, 4'd7, 4'd6, 4'd6, 12'h0), 1'b1, 1'b1, s);
    vectors++;
    if ({s, valid_e} !== 2'b00) begin
      miscompares++;
      $display("FAIL flush: got stall/valid_e=%b want 00", {s, valid_e});
    end
    issue(mk(4'hA, 4'd3, 4'd1, 4'd2, 12'h123), st);
    vectors++;
    if ({valid_e, illegal_e, reg_write_e} !== 3'b110) begin
      miscompares++;
      $display("FAIL illegal: got v/ill/rw=%b want 110", {valid_e, illegal_e, reg_write_e});
    end
  endtask

  task automatic test_reset_mid_stall();
    int st;
    logic s;
    issue(mk(4'h8, 4'd6, 4'd2, 4'd0, 12'h0), st);
    step(mk(4'h0, 4'd7, 4'd6, 4'd6, 12'h0), 1'b1, 1'b0, s);
    #2 rst = 1;
    #1;
    vectors++;
    if ({dut_word(), stall_d, s} !== {{W{1'b0}}, 2'b01}) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got word=%h stall=%b prior_stall=%b want 0 0 1",
               dut_word(), stall_d, s);
    end
    valid_d = 0;
    model_clear();
    #2 rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) step(32'h0, 1'b0, 1'b0, s);
    issue(mk(4'h0, 4'd7, 4'd6, 4'd6, 12'h0), st);
    vectors++;
    if ({st[3:0], valid_e} !== 5'b00001) begin
      miscompares++;
      $display("FAIL after_reset: got stalls=%0d valid_e=%b want 0 1", st, valid_e);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops[10];
    logic [31:0] ins;
    logic s, v, fl;
    ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hF, 4'hC};
    ins = 0; s = 0;
    for (int i = 0; i < 200; i++) begin
      if (!s)
        ins = mk(ops[$urandom_range(0, 9)], 4'($urandom_range(0, 5)),
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                 12'($urandom_range(0, 4095)));
      v = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 9) == 0);
      step(ins, v, fl, s);
    end
  endtask

  initial begin
    test_reset();
    test_forward_alu();
    test_load_use_2();
    test_load_use_1();
    test_r0();
    test_back_to_back();
    test_flush_illegal();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
